// File: rtl/perceptron_predictor_pipe_if.sv
// Predict/resolve bus of the perceptron branch predictor.
// Fetch drives the predict side and the execution unit drives the resolve side.
interface perceptron_predictor_pipe_if #(
  parameter int H            = 8,
  parameter int W            = 8,
  parameter int MAX_INFLIGHT = 4
);
  localparam int Y_W   = W + $clog2(H + 1) + 1;
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  logic                  pred_valid;
  logic [63:0]           pred_ip;
  logic                  pred_ready;
  logic                  out_valid;
  logic                  pred_taken;
  logic signed [Y_W-1:0] pred_y;
  logic                  upd_valid;
  logic                  upd_taken;
  logic                  upd_err;
  logic [INF_W-1:0]      inflight;

  modport master (
    output pred_valid, pred_ip, upd_valid, upd_taken,
    input  pred_ready, out_valid, pred_taken, pred_y, upd_err, inflight
  );

  modport slave (
    input  pred_valid, pred_ip, upd_valid, upd_taken,
    output pred_ready, out_valid, pred_taken, pred_y, upd_err, inflight
  );
endinterface

// File: rtl/perceptron_predictor_pipe.sv
// Perceptron branch predictor: one-cycle predict, in-order resolve from a pending FIFO,
// training on the snapshot captured at predict time with saturating weights.
module perceptron_predictor_pipe #(
  parameter int H            = 8,
  parameter int N            = 64,
  parameter int W            = 8,
  parameter int THETA        = 29,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                       clk,
  input logic                       reset,
  perceptron_predictor_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int Y_W   = W + $clog2(H + 1) + 1;
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] W_MIN = -W_MAX;
  localparam logic signed [W-1:0] W_ONE = 1;

  function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] w,
                                                   input logic               inc);
    if (inc) return (w == W_MAX) ? w : w + W_ONE;
    return (w == W_MIN) ? w : w - W_ONE;
  endfunction

  function automatic logic signed [Y_W-1:0] sext(input logic signed [W-1:0] w);
    return Y_W'(w);
  endfunction

  function automatic logic small_margin(input logic signed [Y_W-1:0] y);
    int v;
    v = int'(y);
    return (v <= THETA) && (v >= -THETA);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  logic signed [W-1:0]   r_w [N][H+1];
  logic [H-1:0]          r_ghr;

  logic [IDX_W-1:0]      r_q_idx [MAX_INFLIGHT];
  logic [H-1:0]          r_q_ghr [MAX_INFLIGHT];
  logic signed [Y_W-1:0] r_q_y   [MAX_INFLIGHT];
  logic                  r_q_dir [MAX_INFLIGHT];
  logic [PTR_W-1:0]      r_wr, r_rd;
  logic [INF_W-1:0]      r_count;

  logic                  r_vld_p1, r_taken_p1, r_err_p1;
  logic signed [Y_W-1:0] r_y_p1;

  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_head_idx;
  logic [H-1:0]          w_head_ghr;
  logic signed [Y_W-1:0] w_sum;
  logic                  w_push, w_pop, w_train;
  logic                  w_unused_ip;

  assign w_idx       = bus.pred_ip[IDX_W-1:0];
  assign w_unused_ip = ^bus.pred_ip[63:IDX_W];
  assign w_head_idx  = r_q_idx[r_rd];
  assign w_head_ghr  = r_q_ghr[r_rd];

  // Stage p0: sum over the bias and the +/-1 history inputs of the addressed entry
  always_comb begin
    w_sum = sext(r_w[w_idx][0]);
    for (int i = 1; i <= H; i++) begin
      if (r_ghr[i-1]) w_sum = w_sum + sext(r_w[w_idx][i]);
      else            w_sum = w_sum - sext(r_w[w_idx][i]);
    end
  end

  // No full-FIFO bypass: a pop in the same cycle does not open a slot early.
  assign bus.pred_ready = !reset && (r_count != INF_W'(MAX_INFLIGHT));
  assign w_push  = bus.pred_valid && bus.pred_ready;
  assign w_pop   = !reset && bus.upd_valid && (r_count != '0);
  assign w_train = (r_q_dir[r_rd] != bus.upd_taken) || small_margin(r_q_y[r_rd]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr] <= w_idx;
      r_q_ghr[r_wr] <= r_ghr;
      r_q_y[r_wr]   <= w_sum;
      r_q_dir[r_wr] <= !w_sum[Y_W-1];
    end
  end

  // Stage p1: registered prediction outputs, FIFO control, training and history update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i <= H; i++)
          r_w[n][i] <= '0;
      r_ghr      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_vld_p1   <= 1'b0;
      r_taken_p1 <= 1'b0;
      r_y_p1     <= '0;
      r_err_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_push;
      r_err_p1 <= bus.upd_valid && (r_count == '0);
      if (w_push) begin
        r_taken_p1 <= !w_sum[Y_W-1];
        r_y_p1     <= w_sum;
        r_wr       <= ptr_next(r_wr);
      end
      if (w_pop) begin
        if (w_train) begin
          r_w[w_head_idx][0] <= sat_step(r_w[w_head_idx][0], bus.upd_taken);
          for (int i = 1; i <= H; i++)
            r_w[w_head_idx][i] <= sat_step(r_w[w_head_idx][i],
                                           bus.upd_taken == w_head_ghr[i-1]);
        end
        r_ghr <= {r_ghr[H-2:0], bus.upd_taken};
        r_rd  <= ptr_next(r_rd);
      end
      r_count <= r_count + INF_W'(w_push) - INF_W'(w_pop);
    end
  end

  assign bus.out_valid  = r_vld_p1;
  assign bus.pred_taken = r_taken_p1;
  assign bus.pred_y     = r_y_p1;
  assign bus.upd_err    = r_err_p1;
  assign bus.inflight   = r_count;
endmodule

// File: tb/tb_perceptron_predictor_pipe.sv
// Bench for perceptron_predictor_pipe: directed scenarios plus random traffic on a default
// instance and a high-threshold instance, checked each cycle against a behavioural model.
module tb_perceptron_predictor_pipe;
  localparam int H     = 8;
  localparam int NENT  = 64;
  localparam int MAXQ  = 4;
  localparam int Y_W   = 8 + $clog2(H + 1) + 1;
  localparam int INF_W = $clog2(MAXQ + 1);

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  perceptron_predictor_pipe_if aif ();
  perceptron_predictor_pipe_if bif ();

  perceptron_predictor_pipe u_a (.clk(clk), .reset(rst_a), .bus(aif.slave));
  perceptron_predictor_pipe #(.THETA(10000)) u_b (.clk(clk), .reset(rst_b), .bus(bif.slave));

  typedef struct {
    int           idx;
    logic [H-1:0] ghr;
    int           y;
    bit           dir;
  } pend_t;

  int           mw    [2][NENT][H+1];
  logic [H-1:0] mghr  [2];
  pend_t        mq    [2][MAXQ];
  int           mcnt  [2];
  int           theta [2];
  bit           e_ov  [2];
  bit           e_tk  [2];
  bit           e_err [2];
  int           e_y   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y(input int k, input int idx);
    int s;
    s = mw[k][idx][0];
    for (int i = 1; i <= H; i++) s += (mghr[k][i-1] ? 1 : -1) * mw[k][idx][i];
    return s;
  endfunction

  task automatic model_edge(input int k, input bit rst, input bit pv, input logic [63:0] ip,
                            input bit uv, input bit ut);
    bit acc, pop;
    int ny, idx, t, x, v;
    logic [H-1:0] ghr_pre;
    pend_t h;
    if (rst) begin
      for (int n = 0; n < NENT; n++)
        for (int i = 0; i <= H; i++) mw[k][n][i] = 0;
      mghr[k] = '0; mcnt[k] = 0;
      e_ov[k] = 0; e_tk[k] = 0; e_y[k] = 0; e_err[k] = 0;
      return;
    end
    acc     = pv && (mcnt[k] < MAXQ);
    pop     = uv && (mcnt[k] > 0);
    e_err[k] = uv && (mcnt[k] == 0);
    idx     = int'(ip % 64);
    ghr_pre = mghr[k];
    ny      = model_y(k, idx);
    if (pop) begin
      h = mq[k][0];
      for (int j = 0; j < MAXQ - 1; j++) mq[k][j] = mq[k][j+1];
      mcnt[k]--;
      t = ut ? 1 : -1;
      if ((h.dir != ut) || ((h.y < 0 ? -h.y : h.y) <= theta[k])) begin
        for (int i = 0; i <= H; i++) begin
          x = (i == 0) ? 1 : (h.ghr[i-1] ? 1 : -1);
          v = mw[k][h.idx][i] + t * x;
          if (v > 127) v = 127;
          if (v < -127) v = -127;
          mw[k][h.idx][i] = v;
        end
      end
      mghr[k] = {mghr[k][H-2:0], ut};
    end
    if (acc) begin
      mq[k][mcnt[k]].idx = idx;
      mq[k][mcnt[k]].ghr = ghr_pre;
      mq[k][mcnt[k]].y   = ny;
      mq[k][mcnt[k]].dir = (ny >= 0);
      mcnt[k]++;
      e_ov[k] = 1; e_y[k] = ny; e_tk[k] = (ny >= 0);
    end else begin
      e_ov[k] = 0;
    end
  endtask

  task automatic check_outs(input int k, input logic ov, input logic tk,
                            input logic signed [Y_W-1:0] y, input logic err,
                            input logic [INF_W-1:0] inf);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, "_out_valid"}, ov, e_ov[k]);
    chk({p, "_pred_taken"}, tk, e_tk[k]);
    chk({p, "_pred_y"}, y, e_y[k]);
    chk({p, "_upd_err"}, err, e_err[k]);
    chk({p, "_inflight"}, inf, mcnt[k]);
  endtask

  task automatic drive(input int k, input bit pv, input logic [63:0] ip, input bit uv,
                       input bit ut);
    if (k == 0) begin
      aif.pred_valid = pv; aif.pred_ip = ip; aif.upd_valid = uv; aif.upd_taken = ut;
    end else begin
      bif.pred_valid = pv; bif.pred_ip = ip; bif.upd_valid = uv; bif.upd_taken = ut;
    end
  endtask

  task automatic tick();
    #1;
    chk("a_pred_ready", aif.pred_ready, !rst_a && (mcnt[0] < MAXQ));
    chk("b_pred_ready", bif.pred_ready, !rst_b && (mcnt[1] < MAXQ));
    @(posedge clk);
    model_edge(0, rst_a, aif.pred_valid, aif.pred_ip, aif.upd_valid, aif.upd_taken);
    model_edge(1, rst_b, bif.pred_valid, bif.pred_ip, bif.upd_valid, bif.upd_taken);
    #1;
    check_outs(0, aif.out_valid, aif.pred_taken, aif.pred_y, aif.upd_err, aif.inflight);
    check_outs(1, bif.out_valid, bif.pred_taken, bif.pred_y, bif.upd_err, bif.inflight);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_pre;
    theta[0] = 29; theta[1] = 10000;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1, 64'h40, 1, 1);
    drive(1, 0, 64'h0, 0, 0);

    // Reset: requests presented during reset are ignored
    tick(); tick();
    chk("rst_out_valid", aif.out_valid, 0);
    chk("rst_pred_y", aif.pred_y, 0);
    chk("rst_inflight", aif.inflight, 0);
    chk("rst_ready", aif.pred_ready, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 0, 64'h0, 0, 0);
    #1;
    chk("ready_after_rst", aif.pred_ready, 1);

    // Cold predict
    drive(0, 1, 64'h40, 0, 0); tick();
    chk("cold_out_valid", aif.out_valid, 1);
    chk("cold_pred_y", aif.pred_y, 0);
    chk("cold_taken", aif.pred_taken, 1);
    chk("cold_inflight", aif.inflight, 1);

    // First training step
    drive(0, 0, 64'h0, 1, 1); tick();
    drive(0, 1, 64'h40, 0, 0); tick();
    chk("train1_pred_y", aif.pred_y, 7);
    chk("train1_taken", aif.pred_taken, 1);
    drive(0, 0, 64'h0, 1, 0); tick();

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 64'h100 + 64'(i), 0, 0); tick();
    end
    chk("bp_inflight_full", aif.inflight, 4);
    chk("bp_ready_full", aif.pred_ready, 0);
    drive(0, 1, 64'h205, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_held_out_valid", aif.out_valid, 0);
    end
    drive(0, 1, 64'h205, 1, 1); tick();
    chk("bp_after_pop_inflight", aif.inflight, 3);
    chk("bp_after_pop_ready", aif.pred_ready, 1);
    drive(0, 1, 64'h205, 0, 0); tick();
    chk("bp_fifth_accepted", aif.out_valid, 1);
    chk("bp_fifth_inflight", aif.inflight, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 64'h0, 1, i[0]); tick();
    end
    chk("bp_drained", aif.inflight, 0);

    // Same cycle predict and resolve on the same index
    drive(0, 1, 64'h7C0, 0, 0); tick();
    exp_pre = model_y(0, 0);
    drive(0, 1, 64'h3C0, 1, 0); tick();
    chk("same_idx_pre_update", aif.pred_y, exp_pre);
    chk("same_idx_inflight", aif.inflight, 1);
    drive(0, 0, 64'h0, 1, 0); tick();
    exp_pre = model_y(0, 0);
    drive(0, 1, 64'h40, 0, 0); tick();
    chk("same_idx_post_train", aif.pred_y, exp_pre);
    drive(0, 0, 64'h0, 1, 1); tick();

    // Resolve with the FIFO empty
    exp_pre = model_y(0, 0);
    drive(0, 0, 64'h0, 1, 1); tick();
    chk("err_pulse", aif.upd_err, 1);
    drive(0, 0, 64'h0, 0, 0); tick();
    chk("err_single", aif.upd_err, 0);
    drive(0, 1, 64'h40, 0, 0); tick();
    chk("err_no_train", aif.pred_y, exp_pre);
    drive(0, 0, 64'h0, 1, 0); tick();

    // Reset with two outstanding predictions
    drive(0, 1, 64'h11, 0, 0); tick();
    drive(0, 1, 64'h12, 0, 0); tick();
    chk("rst_mid_inflight2", aif.inflight, 2);
    rst_a = 1'b1; drive(0, 1, 64'h13, 1, 1); tick();
    rst_a = 1'b0;
    chk("rst_mid_inflight0", aif.inflight, 0);
    drive(0, 0, 64'h0, 1, 1); tick();
    chk("rst_mid_err", aif.upd_err, 1);
    drive(0, 1, 64'h11, 0, 0); tick();
    chk("rst_mid_zero_w", aif.pred_y, 0);
    chk("rst_mid_taken", aif.pred_taken, 1);
    drive(0, 0, 64'h0, 1, 0); tick();

    // Saturation on the high-threshold instance
    drive(0, 0, 64'h0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 64'h40, 0, 0); tick();
      drive(1, 0, 64'h0, 1, 1); tick();
    end
    drive(1, 1, 64'h40, 0, 0); tick();
    chk("sat_pred_y", bif.pred_y, 1143);
    chk("sat_taken", bif.pred_taken, 1);
    drive(1, 0, 64'h0, 1, 1); tick();

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      rst_a = ($urandom_range(0, 99) == 0);
      drive(0, $urandom_range(0, 1) == 1,
            {$urandom(), 26'($urandom()), 6'($urandom_range(0, 3))},
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      drive(1, $urandom_range(0, 1) == 1,
            {$urandom(), 26'($urandom()), 6'($urandom_range(60, 63))},
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      tick();
    end
    rst_a = 1'b0;
    drive(0, 0, 64'h0, 0, 0);
    drive(1, 0, 64'h0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
